// File: rtl/mix_wb_sched.sv
// mix_wb_sched: accepts mix operations from issue, computes the mix result
// into a small result FIFO, and drains that FIFO onto the writeback port it
// shares with the ALU. The ALU has priority on the port. A saturating
// starvation counter stalls the ALU so that pending mix results always drain.
//
// fu_data_i is a packed operand bundle: {trans_id, operand_b, operand_a}.
// operand_a occupies the low XLEN bits.
module mix_wb_sched #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TRANS_ID_BITS  = 3,
  parameter int unsigned EXCEPTION_BITS = 1,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            mix_valid_i,
  input  logic [TRANS_ID_BITS+2*XLEN-1:0] fu_data_i,
  output logic                            mix_ready_o,
  input  logic                            alu_wb_valid_i,
  output logic                            alu_stall_o,
  output logic                            mix_wb_valid_o,
  output logic [XLEN-1:0]                 mix_wb_result_o,
  output logic [TRANS_ID_BITS-1:0]        mix_wb_trans_id_o,
  output logic [EXCEPTION_BITS-1:0]       mix_wb_exception_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [XLEN-1:0]          op_a;
  logic [XLEN-1:0]          op_b;
  logic [TRANS_ID_BITS-1:0] op_tid;
  logic [XLEN-1:0]          mix_result;

  logic [CW-1:0]            count_reg;
  logic [CW-1:0]            count_next;
  logic [PW-1:0]            wr_ptr_reg;
  logic [PW-1:0]            rd_ptr_reg;
  logic [SW-1:0]            starve_reg;
  logic [SW-1:0]            starve_next;

  logic [XLEN-1:0]          res_mem [DEPTH];
  logic [TRANS_ID_BITS-1:0] tid_mem [DEPTH];

  logic                     push;
  logic                     pop;
  logic                     pending;

  assign op_a   = fu_data_i[XLEN-1:0];
  assign op_b   = fu_data_i[2*XLEN-1:XLEN];
  assign op_tid = fu_data_i[TRANS_ID_BITS+2*XLEN-1:2*XLEN];

  // Result is formed at accept time, so the FIFO only ever holds final values.
  assign mix_result = (op_a >> 16) | (op_b << 16);

  // Handshake and grant decode from registered state only, except that the
  // ALU request reaches the grant combinationally (ALU has priority).
  assign pending        = (count_reg != '0);
  assign mix_ready_o    = (count_reg != CW'(DEPTH)) && !flush_i;
  assign alu_stall_o    = (starve_reg == SW'(STARVE_LIMIT));
  assign mix_wb_valid_o = pending && !flush_i && (!alu_wb_valid_i || alu_stall_o);

  assign push = mix_valid_i && mix_ready_o;
  assign pop  = mix_wb_valid_o;

  // Head entry is always visible; it reads as 0 after reset because storage is reset.
  assign mix_wb_result_o    = res_mem[rd_ptr_reg];
  assign mix_wb_trans_id_o  = tid_mem[rd_ptr_reg];
  assign mix_wb_exception_o = '0;

  // Occupancy and starvation next-state; flush and grant both clear starvation.
  always_comb begin
    count_next  = count_reg;
    starve_next = starve_reg;
    if (flush_i) begin
      count_next  = '0;
      starve_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
      if (!pending || pop) begin
        starve_next = '0;
      end else if (alu_wb_valid_i && !alu_stall_o) begin
        starve_next = starve_reg + 1'b1;
      end
    end
  end

  // Control state: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      starve_reg <= '0;
    end else begin
      count_reg  <= count_next;
      starve_reg <= starve_next;
      if (flush_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each entry captures the freshly computed result when it is the write target.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          res_mem[gi] <= '0;
          tid_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          res_mem[gi] <= mix_result;
          tid_mem[gi] <= op_tid;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mix_wb_sched.sv
// Directed bench for mix_wb_sched (XLEN=32, DEPTH=2, STARVE_LIMIT=4).
module tb_mix_wb_sched;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic        mix_valid_i;
  logic [66:0] fu_data_i;
  logic        mix_ready_o;
  logic        alu_wb_valid_i;
  logic        alu_stall_o;
  logic        mix_wb_valid_o;
  logic [31:0] mix_wb_result_o;
  logic [2:0]  mix_wb_trans_id_o;
  logic [0:0]  mix_wb_exception_o;

  int errors = 0;
  int checks = 0;

  mix_wb_sched #(
    .XLEN(32), .TRANS_ID_BITS(3), .EXCEPTION_BITS(1), .DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .mix_valid_i(mix_valid_i), .fu_data_i(fu_data_i), .mix_ready_o(mix_ready_o),
    .alu_wb_valid_i(alu_wb_valid_i), .alu_stall_o(alu_stall_o),
    .mix_wb_valid_o(mix_wb_valid_o), .mix_wb_result_o(mix_wb_result_o),
    .mix_wb_trans_id_o(mix_wb_trans_id_o), .mix_wb_exception_o(mix_wb_exception_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] tid);
    mix_valid_i = v;
    fu_data_i   = {tid, b, a};
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [31:0] res,
                        input logic [2:0] tid);
    chk({tag, "_valid"}, 64'(mix_wb_valid_o), 64'(v));
    if (v) begin
      chk({tag, "_result"}, 64'(mix_wb_result_o), 64'(res));
      chk({tag, "_tid"}, 64'(mix_wb_trans_id_o), 64'(tid));
    end
    $display("txn %s: valid=%0b result=%08h tid=%0d ready=%0b stall=%0b", tag,
             mix_wb_valid_o, mix_wb_result_o, mix_wb_trans_id_o, mix_ready_o, alu_stall_o);
  endtask

  initial begin
    rst_ni         = 1'b1;
    flush_i        = 1'b0;
    mix_valid_i    = 1'b0;
    fu_data_i      = '0;
    alu_wb_valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_ready", 64'(mix_ready_o), 64'd1);
    chk("rst_valid", 64'(mix_wb_valid_o), 64'd0);
    chk("rst_stall", 64'(alu_stall_o), 64'd0);
    chk("rst_result", 64'(mix_wb_result_o), 64'd0);
    chk("rst_tid", 64'(mix_wb_trans_id_o), 64'd0);
    chk("rst_exc", 64'(mix_wb_exception_o), 64'd0);
    tick; tick;
    #3 rst_ni = 1'b1;
    tick;

    // Basic: single op with the ALU idle, written back the next cycle.
    drive_op(1'b1, 32'h1234_5678, 32'h0000_ABCD, 3'd3);
    chk("basic_ready", 64'(mix_ready_o), 64'd1);
    chk_wb("basic_pre", 1'b0, 32'h0, 3'd0);
    tick;
    drive_op(1'b0, 32'h0, 32'h0, 3'd0);
    chk_wb("basic_wb", 1'b1, 32'hABCD_1234, 3'd3);
    chk("basic_exc", 64'(mix_wb_exception_o), 64'd0);
    tick;
    chk_wb("basic_empty", 1'b0, 32'h0, 3'd0);

    // Fill/full: ALU holds the port while three ops are presented.
    alu_wb_valid_i = 1'b1;
    drive_op(1'b1, 32'h0001_0000, 32'h0, 3'd0);
    tick;
    drive_op(1'b1, 32'h0002_0000, 32'h0, 3'd1);
    chk_wb("fill_held1", 1'b0, 32'h0, 3'd0);
    tick;
    drive_op(1'b1, 32'h0003_0000, 32'h0, 3'd2);
    chk("full_ready", 64'(mix_ready_o), 64'd0);
    chk("full_stall", 64'(alu_stall_o), 64'd0);
    chk_wb("fill_held2", 1'b0, 32'h0, 3'd0);
    tick;
    alu_wb_valid_i = 1'b0;
    #1;
    chk("full_ready2", 64'(mix_ready_o), 64'd0);
    chk_wb("drain0", 1'b1, 32'h1, 3'd0);
    tick;
    chk("drain_ready", 64'(mix_ready_o), 64'd1);
    chk_wb("drain1", 1'b1, 32'h2, 3'd1);
    tick;
    drive_op(1'b0, 32'h0, 32'h0, 3'd0);
    chk_wb("drain2", 1'b1, 32'h3, 3'd2);
    tick;
    chk_wb("drain_empty", 1'b0, 32'h0, 3'd0);

    // Starvation: one pending result, ALU stuck requesting.
    alu_wb_valid_i = 1'b1;
    drive_op(1'b1, 32'h0005_0000, 32'h0, 3'd5);
    tick;
    drive_op(1'b0, 32'h0, 32'h0, 3'd0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("starve_c%0d_stall", i), 64'(alu_stall_o), 64'd0);
      chk_wb($sformatf("starve_c%0d", i), 1'b0, 32'h0, 3'd0);
      tick;
    end
    chk("starve_c5_stall", 64'(alu_stall_o), 64'd1);
    chk_wb("starve_c5", 1'b1, 32'h5, 3'd5);
    tick;
    chk("starve_c6_stall", 64'(alu_stall_o), 64'd0);
    chk_wb("starve_c6", 1'b0, 32'h0, 3'd0);
    tick;
    chk("starve_c7_stall", 64'(alu_stall_o), 64'd0);
    alu_wb_valid_i = 1'b0;

    // Back-to-back push/pop with the ALU idle.
    drive_op(1'b1, 32'h0000_0000, 32'h0, 3'd0);
    chk_wb("b2b_pre", 1'b0, 32'h0, 3'd0);
    tick;
    for (int i = 1; i <= 3; i++) begin
      drive_op(1'b1, 32'(i) << 16, 32'h0, 3'(i));
      chk($sformatf("b2b%0d_ready", i), 64'(mix_ready_o), 64'd1);
      chk_wb($sformatf("b2b%0d", i - 1), 1'b1, 32'(i - 1), 3'(i - 1));
      tick;
    end
    drive_op(1'b0, 32'h0, 32'h0, 3'd0);
    chk_wb("b2b3", 1'b1, 32'h3, 3'd3);
    tick;
    chk_wb("b2b_empty", 1'b0, 32'h0, 3'd0);

    // Flush with two pending results and a new op presented.
    alu_wb_valid_i = 1'b1;
    drive_op(1'b1, 32'h0006_0000, 32'h0, 3'd6);
    tick;
    drive_op(1'b1, 32'h0007_0000, 32'h0, 3'd7);
    tick;
    alu_wb_valid_i = 1'b0;
    flush_i        = 1'b1;
    drive_op(1'b1, 32'h0001_0000, 32'h0, 3'd1);
    chk("flush_ready", 64'(mix_ready_o), 64'd0);
    chk("flush_stall", 64'(alu_stall_o), 64'd0);
    chk_wb("flush_cyc", 1'b0, 32'h0, 3'd0);
    tick;
    flush_i = 1'b0;
    drive_op(1'b0, 32'h0, 32'h0, 3'd0);
    chk("post_flush_ready", 64'(mix_ready_o), 64'd1);
    chk_wb("post_flush1", 1'b0, 32'h0, 3'd0);
    tick;
    chk_wb("post_flush2", 1'b0, 32'h0, 3'd0);

    // Asynchronous reset while the FIFO is full.
    alu_wb_valid_i = 1'b1;
    drive_op(1'b1, 32'h00AA_0000, 32'h0000_0001, 3'd1);
    tick;
    drive_op(1'b1, 32'h00BB_0000, 32'h0, 3'd2);
    tick;
    drive_op(1'b0, 32'h0, 32'h0, 3'd0);
    chk("arst_full_ready", 64'(mix_ready_o), 64'd0);
    alu_wb_valid_i = 1'b0;
    #1;
    chk_wb("arst_pre", 1'b1, 32'h0001_00AA, 3'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_ready", 64'(mix_ready_o), 64'd1);
    chk("arst_valid", 64'(mix_wb_valid_o), 64'd0);
    chk("arst_stall", 64'(alu_stall_o), 64'd0);
    chk("arst_result", 64'(mix_wb_result_o), 64'd0);
    chk("arst_tid", 64'(mix_wb_trans_id_o), 64'd0);
    #1 rst_ni = 1'b1;
    tick;
    chk_wb("arst_post1", 1'b0, 32'h0, 3'd0);
    chk("arst_post_ready", 64'(mix_ready_o), 64'd1);
    tick;
    chk_wb("arst_post2", 1'b0, 32'h0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mix_wb_sched.md
# mix_wb_sched

Issue-side controller and writeback scheduler for the custom mix functional unit. It accepts mix operations from issue, computes the mix result into a small result FIFO, and drains that FIFO onto the writeback port the mix unit shares with the ALU. The ALU has priority on the port; a starvation counter guarantees the mix unit forward progress. It sits between issue-read-operands and the shared ALU/mix writeback mux in the execute stage.

## Interface
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration.
- `DEPTH`, default 2: result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, default 4: consecutive ALU-held cycles with pending mix results before the ALU is stalled; ≥1.

Ports:
- `clk_i` input 1: single clock.
- `rst_ni` input 1: asynchronous, active-low reset.
- `flush_i` input 1: pipeline flush.
- `mix_valid_i` input 1: issue presents a mix operation.
- `fu_data_i` input `ariane_pkg::fu_data_t`: operands and `trans_id`.
- `mix_ready_o` output 1: operation can be accepted this cycle.
- `alu_wb_valid_i` input 1: ALU wants the shared writeback port this cycle.
- `alu_stall_o` output 1: ALU must not issue; the port is reserved for mix.
- `mix_wb_valid_o` output 1: mix result owns the shared port this cycle.
- `mix_wb_result_o` output `riscv::XLEN`: mix result.
- `mix_wb_trans_id_o` output `TRANS_ID_BITS`: scoreboard tag of the result.
- `mix_wb_exception_o` output `exception_t`: always `'0`.

## Operation
- Mix result is `(operand_a >> 16) | (operand_b << 16)`, logical shifts, truncated to XLEN, computed at accept time.
- **Push:** on `mix_valid_i && mix_ready_o && !flush_i`, `{result, trans_id}` is written at the write pointer; `count` increments.
- **Ready:** `mix_ready_o = (count != DEPTH) && !flush_i`.
  - Registered count only; no push-through-pop when full.
- **Grant:** `mix_wb_valid_o = (count != 0) && !flush_i && (!alu_wb_valid_i || alu_stall_o)`.
  - When asserted, the head entry drives the result and trans_id outputs and is popped at the clock edge.
- **Result/trans_id when no grant:** outputs show the head entry's stored contents.
  - After reset these are 0.
- **Starvation counter `starve_q`:** 0..STARVE_LIMIT, saturating.
  - Increments when `count != 0 && alu_wb_valid_i && !mix_wb_valid_o`.
  - Clears on any mix grant, when `count == 0`, or on flush.
- **Stall:** `alu_stall_o = (starve_q == STARVE_LIMIT)`, a registered-state decode.
  - While high, mix wins the port even if `alu_wb_valid_i` is high.
  - The ALU source is required to hold its result.
- **Simultaneous push and pop:** both occur; `count` is unchanged and the pointers advance independently.
- **Flush:** FIFO contents are discarded at the next edge (`count`, pointers and `starve_q` go to 0).
  - During the flush cycle: no push, no grant, `mix_ready_o = 0`, `alu_stall_o` still decodes from `starve_q`.
- **Pointer width:** `$clog2(DEPTH)`, wrapping naturally; `count` width is `$clog2(DEPTH)+1`.

## Timing
- **Reset (async assert, sync release):**
  - count, pointers, `starve_q` and FIFO storage are 0.
  - `mix_ready_o = 1`, `mix_wb_valid_o = 0`, `alu_stall_o = 0`.
  - `mix_wb_result_o = 0`, `mix_wb_trans_id_o = 0`, `mix_wb_exception_o = 0`.
- **Latency:** an operation accepted at edge N is eligible for writeback in the cycle after edge N. Minimum issue-to-writeback is 1 cycle.
- **Throughput:** 1 accept and 1 writeback per cycle sustained while the ALU is idle.
- **Stall timing:** `alu_stall_o` rises exactly STARVE_LIMIT blocked cycles after results become pending. It falls in the cycle after the mix grant.
- **Reset mid-operation:** all pending results are lost; nothing is written back after reset release until a new push.
- No combinational path from `mix_valid_i` to any output. `alu_wb_valid_i` reaches `mix_wb_valid_o` combinationally.

## Test plan
- **Basic:** reset, then push a=0x1234_5678, b=0x0000_ABCD, trans_id=3 with the ALU idle → next cycle `mix_wb_valid_o=1`, result=0xABCD_1234 (XLEN=32) with upper bits 0, trans_id=3, exception 0.
- **Fill/full:** hold `alu_wb_valid_i=1` with STARVE_LIMIT large and push 3 ops with DEPTH=2.
  - Third op sees `mix_ready_o=0` and is held.
  - Release the ALU → results drain in order, one per cycle, trans_ids 0,1 then 2.
- **Starvation:** STARVE_LIMIT=4, one pending result, `alu_wb_valid_i` stuck at 1.
  - `alu_stall_o=1` in the 5th cycle, and `mix_wb_valid_o=1` in the same cycle.
  - Stall drops the next cycle and `starve_q` returns to 0.
- **Simultaneous push/pop:** continuous back-to-back pushes with the ALU idle → `count` stays 1, and every op is written back exactly once, 1 cycle after accept.
- **Flush:** 2 pending results; assert `flush_i` for one cycle together with a new `mix_valid_i`.
  - No writeback in the flush cycle or after it, and the new op is not accepted.
  - `mix_ready_o=1` the following cycle.
- **Async reset mid-drain:** assert `rst_ni=0` between clock edges with the FIFO full → all outputs at reset values immediately; after release, no stale writebacks.
